// File: rtl/branch_hazard_controller.sv
// Branch resolution and load-use hazard control for a 5-stage pipeline.
// It redirects the PC on taken EX branches, flushes IF/ID and ID/EX, and stalls on load-use hazards.
module branch_hazard_controller #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_branch,
    input  logic [2:0]  ex_funct3,
    input  logic [63:0] ex_rs1_data,
    input  logic [63:0] ex_rs2_data,
    input  logic [63:0] ex_target,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    output logic        pc_sel,
    output logic [63:0] pc_target,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        illegal_branch,
    output logic [31:0] taken_count,
    output logic [31:0] stall_count
);

    localparam int        DATA_W     = 64;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t              state_q;
    logic [2:0]          flush_cnt_q;
    logic [DATA_W-1:0]   pc_target_q;
    logic                pc_sel_q, pc_write_q, ifid_write_q;
    logic                ifid_flush_q, idex_flush_q, illegal_q;
    logic [31:0]         taken_cnt_q, stall_cnt_q;

    logic                taken_d, hazard_d, illegal_d;

    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic signed [DATA_W-1:0] a,
                                         input logic signed [DATA_W-1:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return a < b;
            3'b101:  return a >= b;
            3'b110:  return $unsigned(a) < $unsigned(b);
            3'b111:  return $unsigned(a) >= $unsigned(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        taken_d   = ex_branch && branch_cond(ex_funct3, $signed(ex_rs1_data), $signed(ex_rs2_data));
        hazard_d  = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        illegal_d = ex_branch && (ex_funct3[2:1] == 2'b01) && (state_q != FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            flush_cnt_q  <= 3'd0;
            pc_target_q  <= '0;
            pc_sel_q     <= 1'b0;
            pc_write_q   <= 1'b1;
            ifid_write_q <= 1'b1;
            ifid_flush_q <= 1'b0;
            idex_flush_q <= 1'b0;
            illegal_q    <= 1'b0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            illegal_q <= illegal_d;
            case (state_q)
                // Flushed slots are bubbles: branch and hazard inputs are not looked at here.
                FLUSH: begin
                    pc_sel_q     <= 1'b0;
                    pc_write_q   <= 1'b1;
                    ifid_write_q <= 1'b1;
                    if (flush_cnt_q > 3'd1) begin
                        flush_cnt_q  <= flush_cnt_q - 3'd1;
                        ifid_flush_q <= 1'b1;
                        idex_flush_q <= 1'b1;
                    end else begin
                        state_q      <= RUN;
                        flush_cnt_q  <= 3'd0;
                        ifid_flush_q <= 1'b0;
                        idex_flush_q <= 1'b0;
                    end
                end
                default: begin
                    if (taken_d) begin
                        state_q      <= FLUSH;
                        flush_cnt_q  <= FLUSH_INIT;
                        pc_target_q  <= ex_target;
                        pc_sel_q     <= 1'b1;
                        pc_write_q   <= 1'b1;
                        ifid_write_q <= 1'b1;
                        ifid_flush_q <= 1'b1;
                        idex_flush_q <= 1'b1;
                        taken_cnt_q  <= sat_inc(taken_cnt_q);
                    end else if (hazard_d) begin
                        state_q      <= STALL;
                        pc_sel_q     <= 1'b0;
                        pc_write_q   <= 1'b0;
                        ifid_write_q <= 1'b0;
                        ifid_flush_q <= 1'b0;
                        idex_flush_q <= 1'b1;
                        stall_cnt_q  <= sat_inc(stall_cnt_q);
                    end else begin
                        state_q      <= RUN;
                        pc_sel_q     <= 1'b0;
                        pc_write_q   <= 1'b1;
                        ifid_write_q <= 1'b1;
                        ifid_flush_q <= 1'b0;
                        idex_flush_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pc_sel         = pc_sel_q;
    assign pc_target      = pc_target_q;
    assign pc_write       = pc_write_q;
    assign ifid_write     = ifid_write_q;
    assign ifid_flush     = ifid_flush_q;
    assign idex_flush     = idex_flush_q;
    assign illegal_branch = illegal_q;
    assign taken_count    = taken_cnt_q;
    assign stall_count    = stall_cnt_q;

endmodule
